// File: rtl/dino_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dino_game_ctrl: per-frame dino runner sequencer (jump, scroll, collide).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dino_game_ctrl #(
  parameter int DINO_X      = 50,
  parameter int DINO_W      = 60,
  parameter int DINO_H      = 60,
  parameter int CACTI_W     = 49,
  parameter int CACTI_H     = 80,
  parameter int GROUND      = 335,
  parameter int CACTI_START = 550,
  parameter int CACTI_MIN   = 10,
  parameter int CACTI_SPEED = 4,
  parameter int JUMP_V0     = 14,
  parameter int GRAVITY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        up,
  input  logic        down,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic [31:0] cacti_x,
  output logic [31:0] cacti_y,
  output logic [15:0] score,
  output logic        game_over,
  output logic        running
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_AIR  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [9:0]  REST_Y   = 10'(GROUND - DINO_H);
  localparam logic [15:0] CX_START = 16'(CACTI_START);
  localparam logic [15:0] CX_MIN   = 16'(CACTI_MIN);
  localparam logic [15:0] CX_SPEED = 16'(CACTI_SPEED);
  localparam logic [7:0]  V0       = 8'(JUMP_V0);
  localparam logic [7:0]  G1       = 8'(GRAVITY);
  localparam logic [31:0] DX       = 32'(DINO_X);
  localparam logic [31:0] DW       = 32'(DINO_W);
  localparam logic [31:0] DH       = 32'(DINO_H);
  localparam logic [31:0] CW       = 32'(CACTI_W);
  localparam logic [31:0] CH       = 32'(CACTI_H);
  localparam logic [31:0] CY       = 32'(GROUND - CACTI_H);

  logic [1:0]  state_q, state_d;
  logic [9:0]  dino_y_q, dino_y_d;
  logic [7:0]  vy_q, vy_d;
  logic [15:0] cacti_x_q, cacti_x_d;
  logic [15:0] score_q, score_d;
  logic        ft_q, ft_d;

  logic               edge_w;
  logic               hit_w;
  logic [31:0]        cx_w, dy_w;
  logic [15:0]        cx_step_w, score_step_w;
  logic [7:0]         g_w;
  logic signed [10:0] s_w;

  always_comb begin
    ft_d   = frame_tick;
    edge_w = frame_tick & ~ft_q;

    cx_w  = {16'd0, cacti_x_q};
    dy_w  = {22'd0, dino_y_q};
    hit_w = (DX < cx_w + CW) && (cx_w < DX + DW) &&
            (dy_w < CY + CH) && (CY < dy_w + DH);

    if (cacti_x_q < CX_MIN) begin
      cx_step_w    = CX_START;
      score_step_w = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
    end else begin
      cx_step_w    = cacti_x_q - CX_SPEED;
      score_step_w = score_q;
    end

    g_w = down ? (G1 << 1) : G1;
    s_w = $signed({1'b0, dino_y_q}) + $signed({{3{vy_q[7]}}, vy_q});

    state_d   = state_q;
    dino_y_d  = dino_y_q;
    vy_d      = vy_q;
    cacti_x_d = cacti_x_q;
    score_d   = score_q;

    case (state_q)
      S_IDLE: begin
        if (edge_w && up) state_d = S_RUN;
      end
      S_RUN: begin
        // A collision on the registered sprites wins over a coincident frame edge.
        if (hit_w) begin
          state_d = S_OVER;
        end else if (edge_w) begin
          cacti_x_d = cx_step_w;
          score_d   = score_step_w;
          if (up) begin
            state_d  = S_AIR;
            dino_y_d = REST_Y - {2'b00, V0};
            vy_d     = G1 - V0;
          end
        end
      end
      S_AIR: begin
        if (hit_w) begin
          state_d = S_OVER;
        end else if (edge_w) begin
          cacti_x_d = cx_step_w;
          score_d   = score_step_w;
          if (s_w >= $signed({1'b0, REST_Y})) begin
            state_d  = S_RUN;
            dino_y_d = REST_Y;
            vy_d     = 8'd0;
          end else begin
            dino_y_d = s_w[10] ? 10'd0 : s_w[9:0];
            vy_d     = vy_q + g_w;
          end
        end
      end
      S_OVER: begin
        if (edge_w && up) begin
          state_d   = S_IDLE;
          dino_y_d  = REST_Y;
          vy_d      = 8'd0;
          cacti_x_d = CX_START;
          score_d   = 16'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The strobe history keeps tracking through reset so release never fakes an edge.
  always_ff @(posedge clk) begin
    ft_q <= ft_d;
    if (reset) begin
      state_q   <= S_IDLE;
      dino_y_q  <= REST_Y;
      vy_q      <= 8'd0;
      cacti_x_q <= CX_START;
      score_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      dino_y_q  <= dino_y_d;
      vy_q      <= vy_d;
      cacti_x_q <= cacti_x_d;
      score_q   <= score_d;
    end
  end

  assign dino_x    = DX;
  assign cacti_y   = CY;
  assign dino_y    = {22'd0, dino_y_q};
  assign cacti_x   = {16'd0, cacti_x_q};
  assign score     = score_q;
  assign game_over = (state_q == S_OVER);
  assign running   = (state_q == S_RUN) || (state_q == S_AIR);

endmodule
`default_nettype wire

// File: tb/tb_dino_game_ctrl.sv
`default_nettype none
// Bench for dino_game_ctrl: two instances (default and DINO_X=600) against a
// frame-level game model, directed scenarios followed by random play.
module tb_dino_game_ctrl;

  localparam int REST = 275;
  localparam int CYV  = 255;
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_AIR = 2, MD_OVER = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic up = 1'b0;
  logic down = 1'b0;

  logic [31:0] o_dx [2];
  logic [31:0] o_dy [2];
  logic [31:0] o_cx [2];
  logic [31:0] o_cy [2];
  logic [15:0] o_sc [2];
  logic        o_go [2];
  logic        o_run[2];

  int n_checks = 0;
  int n_err    = 0;

  int m_mode[2], m_y[2], m_vy[2], m_cx[2], m_sc[2];
  int m_dx[2] = '{50, 600};

  always #5 clk = ~clk;

  dino_game_ctrl u_near (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
    .dino_x(o_dx[0]), .dino_y(o_dy[0]), .cacti_x(o_cx[0]), .cacti_y(o_cy[0]),
    .score(o_sc[0]), .game_over(o_go[0]), .running(o_run[0])
  );

  dino_game_ctrl #(.DINO_X(600)) u_far (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
    .dino_x(o_dx[1]), .dino_y(o_dy[1]), .cacti_x(o_cx[1]), .cacti_y(o_cy[1]),
    .score(o_sc[1]), .game_over(o_go[1]), .running(o_run[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_mode[k] = MD_IDLE; m_y[k] = REST; m_vy[k] = 0; m_cx[k] = 550; m_sc[k] = 0;
  endtask

  function automatic bit collides(input int k);
    return (m_dx[k] < m_cx[k] + 49) && (m_cx[k] < m_dx[k] + 60) &&
           (m_y[k] < CYV + 80) && (CYV < m_y[k] + 60);
  endfunction

  task automatic model_frame(input int k, input bit u, input bit d);
    int s;
    case (m_mode[k])
      MD_IDLE: if (u) m_mode[k] = MD_RUN;
      MD_OVER: if (u) model_reset(k);
      default: begin
        if (m_cx[k] < 10) begin
          m_cx[k] = 550;
          if (m_sc[k] < 65535) m_sc[k]++;
        end else begin
          m_cx[k] -= 4;
        end
        if (m_mode[k] == MD_RUN) begin
          if (u) begin
            m_y[k] = REST - 14; m_vy[k] = -13; m_mode[k] = MD_AIR;
          end
        end else begin
          s = m_y[k] + m_vy[k];
          if (s >= REST) begin
            m_y[k] = REST; m_vy[k] = 0; m_mode[k] = MD_RUN;
          end else begin
            m_y[k] = (s < 0) ? 0 : s;
            m_vy[k] += d ? 2 : 1;
          end
        end
      end
    endcase
    if ((m_mode[k] == MD_RUN || m_mode[k] == MD_AIR) && collides(k)) m_mode[k] = MD_OVER;
  endtask

  task automatic check_all(input int k);
    chk($sformatf("i%0d dino_y", k), o_dy[k], m_y[k]);
    chk($sformatf("i%0d cacti_x", k), o_cx[k], m_cx[k]);
    chk($sformatf("i%0d score", k), {16'd0, o_sc[k]}, m_sc[k]);
    chk($sformatf("i%0d game_over", k), {31'd0, o_go[k]}, (m_mode[k] == MD_OVER) ? 1 : 0);
    chk($sformatf("i%0d running", k), {31'd0, o_run[k]},
        (m_mode[k] == MD_RUN || m_mode[k] == MD_AIR) ? 1 : 0);
  endtask

  task automatic do_frame(input bit u, input bit d, input int w);
    @(negedge clk);
    up = u; down = d; frame_tick = 1'b1;
    repeat (w) @(negedge clk);
    frame_tick = 1'b0;
    model_frame(0, u, d);
    model_frame(1, u, d);
    repeat (2) @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all(0);
    check_all(1);
    chk("dino_x near", o_dx[0], 50);
    chk("dino_x far", o_dx[1], 600);
    chk("cacti_y", o_cy[0], 255);

    // Idle frames with up low stay put
    for (int i = 0; i < 3; i++) begin
      do_frame(1'b0, 1'b0, 1);
      chk("idle running", {31'd0, o_run[0]}, 0);
      chk("idle dino_y", o_dy[0], 275);
    end

    // Start and run straight into the first cactus
    do_frame(1'b1, 1'b0, 2);
    for (int f = 1; f <= 110; f++) do_frame(1'b0, 1'b0, 1 + (f % 3));
    chk("run110 cacti_x", o_cx[0], 110);
    chk("run110 game_over", {31'd0, o_go[0]}, 0);

    @(negedge clk);
    up = 1'b0; down = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    chk("E+1 cacti_x", o_cx[0], 106);
    chk("E+1 game_over", {31'd0, o_go[0]}, 0);
    @(negedge clk);
    chk("E+2 game_over", {31'd0, o_go[0]}, 1);
    chk("E+2 running", {31'd0, o_run[0]}, 0);
    frame_tick = 1'b0;
    model_frame(0, 1'b0, 1'b0);
    model_frame(1, 1'b0, 1'b0);
    @(negedge clk);
    check_all(0);
    check_all(1);
    for (int i = 0; i < 3; i++) do_frame(1'b0, 1'b0, 2);
    chk("frozen cacti_x", o_cx[0], 106);

    // Plain jump on the far instance
    for (int j = 1; j <= 29; j++) begin
      do_frame(j == 1, 1'b0, 1);
      if (j == 1)  chk("jump f1", o_dy[1], 261);
      if (j == 2)  chk("jump f2", o_dy[1], 248);
      if (j == 14) chk("jump f14", o_dy[1], 170);
      if (j == 15) chk("jump f15", o_dy[1], 170);
      if (j == 28) chk("jump f28", o_dy[1], 261);
      if (j == 29) begin
        chk("jump land", o_dy[1], 275);
        chk("jump land running", {31'd0, o_run[1]}, 1);
      end
    end

    // Jump with fast-fall on the way down
    for (int j = 1; j <= 25; j++) begin
      do_frame(j == 1, j >= 15, 1);
      if (j == 24) chk("fastfall f24", o_dy[1], 260);
      if (j == 25) chk("fastfall land", o_dy[1], 275);
    end

    // Cactus wrap and scoring
    apply_reset();
    do_frame(1'b1, 1'b0, 1);
    for (int f = 1; f <= 137; f++) begin
      do_frame(1'b0, 1'b0, 1);
      if (f == 135) chk("wrap f135", o_cx[1], 10);
      if (f == 136) chk("wrap f136", o_cx[1], 6);
      if (f == 137) begin
        chk("wrap f137", o_cx[1], 550);
        chk("wrap score", {16'd0, o_sc[1]}, 1);
      end
    end

    // Wide strobes, then reset mid-jump while the strobe is high
    do_frame(1'b1, 1'b0, 4);
    do_frame(1'b0, 1'b0, 4);
    do_frame(1'b0, 1'b0, 4);
    chk("wide jump f3", o_dy[1], 236);
    @(negedge clk);
    up = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b1; up = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
    check_all(0);
    check_all(1);
    repeat (3) @(negedge clk);
    chk("no false edge running", {31'd0, o_run[1]}, 0);
    chk("no false edge dino_y", o_dy[1], 275);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_all(0);
    check_all(1);

    // Random play
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(49) == 0) apply_reset();
      do_frame($urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(5, 1));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Per-frame game sequencer for the dino runner display. Owns dino vertical position (jump/gravity), cactus horizontal scroll, collision detection, score and game-over state. Advances once per video frame on the rising edge of the display's frame-end strobe and drives the sprite coordinates the VGA controller consumes.

## Interface
Parameters:
- DINO_X, 50: fixed dino left edge (px)
- DINO_W, 60 / DINO_H, 60: dino box size
- CACTI_W, 49 / CACTI_H, 80: cactus box size
- GROUND, 335: ground line y
- CACTI_START, 550: cactus reload x
- CACTI_MIN, 10: cactus wraps when x < CACTI_MIN
- CACTI_SPEED, 4: px per frame
- JUMP_V0, 14: takeoff speed (px/frame)
- GRAVITY, 1: px/frame² added to vy

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  frame-end strobe, level, multi-cycle high; only its 0→1 edge counts
- up  in  1  jump / start / restart, level
- down  in  1  fast-fall, level
- dino_x  out  32  constant DINO_X
- dino_y  out  32  dino top edge, zero-extended
- cacti_x  out  32  cactus left edge
- cacti_y  out  32  constant GROUND−CACTI_H
- score  out  16  cactus wraps survived
- game_over  out  1  high in GAME_OVER
- running  out  1  high in RUN or AIR

## Operation
- REST_Y = GROUND−DINO_H (275). Edge E = frame_tick & ~ft_q; ft_q samples frame_tick every cycle, reset included (no false edge on reset release).
- States: IDLE, RUN, AIR, GAME_OVER. Reset → IDLE, dino_y=REST_Y, vy=0, cacti_x=CACTI_START, score=0.
- IDLE: on E with up=1 → RUN; no motion that frame.
- RUN, on E: cactus step; if up=1 → AIR, dino_y←REST_Y−JUMP_V0, vy←−JUMP_V0+GRAVITY. down ignored.
- AIR, on E: cactus step; g = down ? 2·GRAVITY : GRAVITY; s = dino_y+vy (11-bit signed). If s ≥ REST_Y → dino_y←REST_Y, vy←0, → RUN. Else dino_y←max(s,0), vy←vy+g.
- Cactus step: if cacti_x < CACTI_MIN → cacti_x←CACTI_START, score←score+1 (saturate 0xFFFF); else cacti_x←cacti_x−CACTI_SPEED.
- Collision (RUN/AIR, every cycle, on registered values): DINO_X < cacti_x+CACTI_W && cacti_x < DINO_X+DINO_W && dino_y < cacti_y+CACTI_H && cacti_y < dino_y+DINO_H → GAME_OVER next cycle. Collision has priority over E in the same cycle (E ignored).
- GAME_OVER: all positions/score frozen. On E with up=1 → IDLE with reset values (score cleared). Held up therefore gives IDLE, then RUN on the next frame.
- dino_y internal 10-bit unsigned, vy 8-bit signed; outputs zero-extended.

## Timing
- Edge cycle E: state, positions, score registered; visible at E+1.
- Collision evaluated at E+1; game_over/running change at E+2.
- Exactly one update per frame_tick rising edge regardless of strobe width.
- Reset mid-frame or mid-jump: all outputs at reset values the cycle after reset is sampled high.

## Test plan
- Reset, then frame edges with up=0 → stays IDLE; dino_y=275, cacti_x=550, score=0, running=0 throughout.
- Defaults, up pulsed on frame 1 only (→RUN), no jumps → after RUN frame 110 cacti_x=110, game_over=0; after frame 111 cacti_x=106, game_over=1 at E+2; further edges change nothing.
- DINO_X=600 (no collision), RUN, up at one edge → dino_y 261, 248, … 170 after jump frame 14 and 15, back to 275 and running-in-RUN after frame 29; never below 0.
- Same, down held during descent → landing frame count shorter than 29; dino_y=275 exactly on landing (no overshoot).
- DINO_X=600, RUN for 137 frames → cacti_x=10 after 135, 6 after 136, 550 and score=1 after 137.
- frame_tick held high 4 cycles per edge, reset asserted mid-jump with frame_tick high → one update per edge; after reset all outputs reset, no spurious update on release.
